// File: rtl/golden_run_sequencer_if.sv
// rtl/golden_run_sequencer_if.sv - campaign-controller <-> run sequencer bus (GOLDEN_CMP_EN adds compare ports)
interface golden_run_sequencer_if #(
  parameter int PORT_WIDTH = 8,
  parameter int NUM_PORTS  = 3,
  parameter int CNT_WIDTH  = 16
);
  logic                            start;
  logic [NUM_PORTS*PORT_WIDTH-1:0] ports_in;
  logic                            dut_reset;
  logic                            busy;
  logic                            done;
  logic [CNT_WIDTH-1:0]            cycle_count;
  logic [31:0]                     signature;
`ifdef GOLDEN_CMP_EN
  logic [31:0]                     expected_sig;
  logic                            mismatch;

  modport master (output start, ports_in, expected_sig,
                  input  dut_reset, busy, done, cycle_count, signature, mismatch);
  modport slave  (input  start, ports_in, expected_sig,
                  output dut_reset, busy, done, cycle_count, signature, mismatch);
`else
  modport master (output start, ports_in,
                  input  dut_reset, busy, done, cycle_count, signature);
  modport slave  (input  start, ports_in,
                  output dut_reset, busy, done, cycle_count, signature);
`endif
endinterface

// File: rtl/golden_run_sequencer.sv
// rtl/golden_run_sequencer.sv - core reset phase sequencer with 32-bit MISR signature; GOLDEN_CMP_EN adds golden compare
module golden_run_sequencer #(
  parameter int PORT_WIDTH  = 8,
  parameter int NUM_PORTS   = 3,
  parameter int PRE_CYCLES  = 1,
  parameter int RUN_CYCLES  = 100,
  parameter int HOLD_CYCLES = 900,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  golden_run_sequencer_if.slave bus
);
  if (NUM_PORTS * PORT_WIDTH > 32) begin : g_width_err
    $error("NUM_PORTS*PORT_WIDTH must not exceed 32");
  end
  if (PRE_CYCLES < 1 || RUN_CYCLES < 1 || HOLD_CYCLES < 0 ||
      PRE_CYCLES >= (1 << CNT_WIDTH) || RUN_CYCLES >= (1 << CNT_WIDTH) ||
      HOLD_CYCLES >= (1 << CNT_WIDTH)) begin : g_cycles_err
    $error("illegal *_CYCLES parameter");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_RUN, S_HOLD, S_DONE} state_t;

  localparam logic [31:0]          POLY    = 32'h04C11DB7;
  localparam logic [CNT_WIDTH-1:0] PRE_LD  = CNT_WIDTH'(PRE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LD  = CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LD = CNT_WIDTH'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_phase_cnt, w_phase_nxt;
  logic [CNT_WIDTH-1:0] r_cycle_count, w_cycle_nxt;
  logic [31:0]          r_sig, w_sig_nxt, w_misr;
  logic                 r_dut_reset, r_busy, r_done;

  assign w_misr = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ 32'(bus.ports_in);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase_cnt;
    w_cycle_nxt = r_cycle_count;
    w_sig_nxt   = r_sig;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_sig_nxt   = 32'hFFFF_FFFF;
          w_cycle_nxt = '0;
          w_phase_nxt = PRE_LD;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        if (r_phase_cnt == '0) begin
          w_phase_nxt = RUN_LD;
          w_state_nxt = S_RUN;
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_ONE;
        end
      end
      S_RUN: begin
        w_sig_nxt = w_misr;
        if (r_cycle_count != CNT_MAX) w_cycle_nxt = r_cycle_count + CNT_ONE;
        if (r_phase_cnt == '0) begin
          w_phase_nxt = HOLD_LD;
          w_state_nxt = (HOLD_CYCLES == 0) ? S_DONE : S_HOLD;
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (r_phase_cnt == '0) w_state_nxt = S_DONE;
        else                   w_phase_nxt = r_phase_cnt - CNT_ONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= '0;
      r_cycle_count <= '0;
      r_sig         <= 32'hFFFF_FFFF;
      r_dut_reset   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_cnt   <= w_phase_nxt;
      r_cycle_count <= w_cycle_nxt;
      r_sig         <= w_sig_nxt;
      r_dut_reset   <= (w_state_nxt != S_RUN);
      r_busy        <= (w_state_nxt == S_PRE) || (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

`ifdef GOLDEN_CMP_EN
  logic r_mismatch;

  // Compare the final signature as it is written, so HOLD_CYCLES=0 needs no extra cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mismatch <= 1'b0;
    end else if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      r_mismatch <= (w_sig_nxt != bus.expected_sig);
    end else if (w_state_nxt == S_PRE) begin
      r_mismatch <= 1'b0;
    end
  end

  assign bus.mismatch = r_mismatch;
`endif

  assign bus.dut_reset   = r_dut_reset;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.cycle_count = r_cycle_count;
  assign bus.signature   = r_sig;
endmodule

// File: doc/golden_run_sequencer.md
# golden_run_sequencer

Synthesizable run sequencer and signature monitor for golden-run and fault-injection campaigns on processor cores.
- Drives the core's reset through a parametrised pre-reset / run / hold phase schedule.
- Compresses the core's output ports into a 32-bit MISR signature during the run phase.
- Sits between the campaign controller and the core under test, so run length and golden-signature capture no longer depend on bench delays.

## Interface
Parameters:
- PORT_WIDTH, 8, width of one monitored port
- NUM_PORTS, 3, number of monitored ports; NUM_PORTS*PORT_WIDTH must be ≤ 32 (elaboration error otherwise)
- PRE_CYCLES, 1, cycles the core is held in reset before the run (≥1)
- RUN_CYCLES, 100, cycles the core runs with its reset released (≥1)
- HOLD_CYCLES, 900, cycles the core is held in reset after the run (≥0)
- CNT_WIDTH, 16, phase/cycle counter width; every *_CYCLES value must be < 2^CNT_WIDTH

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  start request; sampled only in IDLE or DONE
- ports_in  in  NUM_PORTS*PORT_WIDTH  core output ports, concatenated; port 0 in the LSBs
- dut_reset  out  1  active-high reset to the core
- busy  out  1  high in PRE, RUN and HOLD
- done  out  1  high in DONE
- cycle_count  out  CNT_WIDTH  number of RUN cycles completed
- signature  out  32  MISR state

## Operation
States: IDLE, PRE, RUN, HOLD, DONE. One down-counter, `phase_cnt`, tracks cycles left in the current phase.
- IDLE/DONE with start=1: signature ← 0xFFFFFFFF, cycle_count ← 0, phase_cnt ← PRE_CYCLES−1, next state PRE.
- PRE: dut_reset=1. At phase_cnt=0: phase_cnt ← RUN_CYCLES−1, next state RUN.
- RUN: dut_reset=0. Every cycle:
  - signature ← {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ zero_ext(ports_in)
  - cycle_count ← cycle_count+1
  - At phase_cnt=0: next state HOLD, or DONE if HOLD_CYCLES=0, with phase_cnt ← HOLD_CYCLES−1.
- HOLD: dut_reset=1. Signature frozen. At phase_cnt=0: next state DONE.
- DONE: dut_reset=1. signature and cycle_count hold until the next start.
- start while busy is ignored; there is no abort other than reset.
- cycle_count saturates at 2^CNT_WIDTH−1; this is unreachable with legal parameters.

## Timing
- Reset values: state IDLE, dut_reset=1, busy=0, done=0, cycle_count=0, signature=0xFFFFFFFF, mismatch=0.
- dut_reset is also 1 in IDLE, so the core never runs unsequenced.
- All outputs are registered. Outputs reflect the new state the cycle after the transition edge.
- start accepted at edge N: busy=1 and dut_reset=1 from N+1.
- dut_reset low window: exactly RUN_CYCLES cycles, starting PRE_CYCLES cycles after the first busy cycle.
- ports_in is sampled at each rising edge while in RUN; the first sample is taken the edge after dut_reset falls.
- Total busy duration: PRE_CYCLES+RUN_CYCLES+HOLD_CYCLES cycles. done rises on the following cycle.
- reset asserted mid-run: everything returns asynchronously to the reset values, and dut_reset goes to 1 immediately.
- start held high continuously in DONE: a new sequence begins on the next edge.

## Configuration
- GOLDEN_CMP_EN defined:
  - Adds input `expected_sig` (32) and output `mismatch` (1).
  - mismatch is registered on the DONE entry edge as (signature_final != expected_sig).
  - mismatch holds through DONE and clears on start or reset.
- GOLDEN_CMP_EN undefined: neither port exists and no comparator logic is built.

## Test plan
- Reset then idle: dut_reset=1, busy=0, done=0, signature=0xFFFFFFFF for 10 cycles with start=0.
- PRE=1, RUN=4, HOLD=2, one-cycle start pulse -> dut_reset pattern 1,0,0,0,0,1,1 over the busy cycles; busy high 7 cycles; done=1 on the 8th; cycle_count=4.
- RUN=1, ports_in=0 -> signature=0xFB3EE249 in DONE.
- Default parameters (RUN=100, HOLD=900) -> busy for exactly 1001 cycles; start pulses during busy ignored.
- reset dropped during RUN cycle 50 -> all outputs at reset values immediately; a new start gives a full 100-cycle run with cycle_count=100.
- GOLDEN_CMP_EN, RUN=1, ports_in=0:
  - expected_sig=0xFB3EE249 -> mismatch=0.
  - expected_sig=0 -> mismatch=1.
  - next start -> mismatch=0.
